// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among NUM_IN producers
module fifo_wr_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int CH_W       = $clog2(NUM_IN)
) (
    input  logic                         in_clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            s_valid,
    output logic [NUM_IN-1:0]            s_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_IN-1:0]            s_last,
    input  logic [NUM_IN-1:0]            chan_en,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]              m_chan,
    output logic                         m_last,
    output logic                         busy
);

    localparam int                CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_IN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [NUM_IN-1:0] req;
    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   pick;
    logic              pick_found;
    logic              in_burst;
    logic              g_valid;
    logic              g_last;
    logic              xfer;

    assign req      = s_valid & chan_en;
    assign in_burst = (state_q == BURST);
    assign g_valid  = s_valid[grant_q];
    assign g_last   = s_last[grant_q];

    // Search upward from the channel after the last one served, wrapping.
    always_comb begin
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = CH_W'((int'(last_grant_q) + k) % NUM_IN);
            if (!pick_found && req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        m_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q == CH_W'(i)) begin
                m_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        s_ready = '0;
        if (in_burst) begin
            s_ready[grant_q] = m_ready;
        end
    end

    assign m_valid = in_burst & g_valid;
    assign m_last  = m_valid & (g_last | (beat_cnt_q == LAST_CNT));
    assign m_chan  = grant_q;
    assign busy    = in_burst;
    assign xfer    = m_valid & m_ready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // The counter stops at BURST_LEN at most, since m_last forces IDLE first.
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (m_last) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_CH;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  s_valid, s_ready, s_last, chan_en;
    logic [31:0] s_data;
    logic        m_valid, m_ready, m_last, busy;
    logic [7:0]  m_data;
    logic [1:0]  m_chan;

    logic        rst1;
    logic [3:0]  s_valid1, s_ready1, s_last1, chan_en1;
    logic [31:0] s_data1;
    logic        m_valid1, m_ready1, m_last1, busy1;
    logic [7:0]  m_data1;
    logic [1:0]  m_chan1;

    fifo_wr_arbiter #(.NUM_IN(4), .DATA_WIDTH(8), .BURST_LEN(16)) dut (
        .in_clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .chan_en(chan_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
        .m_last(m_last), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_IN(4), .DATA_WIDTH(8), .BURST_LEN(1)) dut1 (
        .in_clk(clk), .rst(rst1),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1), .s_last(s_last1),
        .chan_en(chan_en1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_chan(m_chan1),
        .m_last(m_last1), .busy(busy1)
    );

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t q[$];
    beat_t q1[$];
    beat_t e;
    beat_t e1;

    int seq[4];
    int rem[4];
    int last_mod[4];
    int n_pass  = 0;
    int n_total = 0;
    int phase   = 0;
    bit rand_ready = 1'b0;
    bit mon1_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] beat_data(input int ch, input int s);
        return 8'((ch * 32) + (s % 32));
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_valid[i]          = (rem[i] > 0);
            s_data[i*8 +: 8]    = beat_data(i, seq[i]);
            s_last[i]           = (last_mod[i] != 0) && ((seq[i] % last_mod[i]) == last_mod[i] - 1);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            seq[i]      = 0;
            rem[i]      = 0;
            last_mod[i] = 0;
        end
    endtask

    task automatic exp_burst(input int ch, input int first, input int n, input bit last);
        for (int j = 0; j < n; j++) begin
            q.push_back('{ch, beat_data(ch, first + j), last && (j == n - 1)});
        end
    endtask

    // Producer model: advance a channel after each accepted beat.
    task automatic cycle();
        logic [3:0] hs;
        @(negedge clk);
        hs = s_valid & s_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                seq[i]++;
                rem[i]--;
            end
        end
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        drive();
    endtask

    function automatic bit pending(input logic [3:0] mask);
        if (q.size() != 0) return 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && rem[i] > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_until(input logic [3:0] mask, input int budget, input string name);
        int n = 0;
        while (pending(mask) && n < budget) begin
            cycle();
            n++;
        end
        if (pending(mask)) begin
            n_total++;
            $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, q.size(), budget);
            q.delete();
        end
        cycle();
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL extra_beat: got chan %0d data %0h, expected no beat", m_chan, m_data);
            end else begin
                e = q.pop_front();
                chk("beat_chan", 32'(m_chan), 32'(e.ch));
                chk("beat_data", 32'(m_data), 32'(e.data));
                chk("beat_last", 32'(m_last), 32'(e.last));
            end
        end
        if (!rst && phase == 3 && busy) chk("bp_s_ready", 32'(s_ready), 32'({2'b00, m_ready, 1'b0}));
        if (!rst && phase == 4) chk("mask_s_ready", 32'(s_ready & 4'b0101), 32'd0);
    end

    always @(negedge clk) begin
        if (mon1_en && !rst1 && m_valid1 && m_ready1) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL bl1_extra_beat: got chan %0d, expected no beat", m_chan1);
            end else begin
                e1 = q1.pop_front();
                chk("bl1_chan", 32'(m_chan1), 32'(e1.ch));
                chk("bl1_data", 32'(m_data1), 32'(e1.data));
                chk("bl1_last", 32'(m_last1), 32'(e1.last));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        rst1     = 1'b1;
        m_ready  = 1'b1;
        m_ready1 = 1'b1;
        chan_en  = 4'hF;
        chan_en1 = 4'hF;
        s_valid1 = 4'b0000;
        s_last1  = 4'b0000;
        s_data1  = 32'h13121110;
        clr();
        drive();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_m_chan",  32'(m_chan),  32'd0);
        @(posedge clk);
        #1;

        // Round robin, full 16-beat bursts: 0,1,2,3,0.
        phase = 1;
        clr();
        rem[0] = 32; rem[1] = 16; rem[2] = 16; rem[3] = 16;
        exp_burst(0, 0, 16, 1);
        exp_burst(1, 0, 16, 1);
        exp_burst(2, 0, 16, 1);
        exp_burst(3, 0, 16, 1);
        exp_burst(0, 16, 16, 1);
        drive();
        run_until(4'hF, 400, "rr");

        // Early end by s_last on 5th beat, then re-grant of the same channel.
        phase = 2;
        clr();
        rem[2] = 10; last_mod[2] = 5;
        exp_burst(2, 0, 5, 1);
        exp_burst(2, 5, 5, 1);
        drive();
        run_until(4'b0100, 100, "slast");

        // Random backpressure during a channel-1 burst.
        phase = 3;
        clr();
        rem[1] = 16;
        exp_burst(1, 0, 16, 1);
        rand_ready = 1'b1;
        drive();
        run_until(4'b0010, 300, "bp");
        rand_ready = 1'b0;
        m_ready    = 1'b1;

        // Mask 1010: last_grant is 1, so channel 3 goes first.
        phase = 4;
        clr();
        chan_en = 4'b1010;
        rem[0] = 5; rem[1] = 32; rem[2] = 5; rem[3] = 32;
        exp_burst(3, 0, 16, 1);
        exp_burst(1, 0, 16, 1);
        exp_burst(3, 16, 16, 1);
        exp_burst(1, 16, 16, 1);
        drive();
        run_until(4'b1010, 400, "mask");
        phase   = 0;
        chan_en = 4'hF;
        clr();
        drive();

        // Reset after 7 beats of a channel-3 burst.
        phase = 5;
        clr();
        rem[3] = 10; last_mod[3] = 10;
        exp_burst(3, 0, 7, 0);
        drive();
        n = 0;
        while (rem[3] > 3 && n < 100) begin
            cycle();
            n++;
        end
        chk("rst_mid_beats_done", 32'(rem[3]), 32'd3);
        rst     = 1'b1;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        rem[0] = 3; last_mod[0] = 3;
        drive();
        @(negedge clk);
        chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_busy",    32'(busy),    32'd0);
        chk("rst_mid_s_ready", 32'(s_ready), 32'd0);
        chk("rst_mid_q_empty", 32'(q.size()), 32'd0);
        exp_burst(0, 0, 3, 1);
        exp_burst(3, 7, 3, 1);
        run_until(4'b1001, 200, "rst_regrant");
        phase = 0;

        // BURST_LEN=1 instance: 0,1,0,1 with one idle cycle between beats.
        phase    = 6;
        s_valid1 = 4'b0011;
        rst1     = 1'b0;
        mon1_en  = 1'b1;
        q1.push_back('{0, 8'h10, 1'b1});
        q1.push_back('{1, 8'h11, 1'b1});
        q1.push_back('{0, 8'h10, 1'b1});
        q1.push_back('{1, 8'h11, 1'b1});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("bl1_valid_pattern", 32'(m_valid1), 32'(k % 2));
        end
        @(posedge clk);
        #1;
        rst1    = 1'b1;
        mon1_en = 1'b0;
        chk("bl1_q_empty", 32'(q1.size()), 32'd0);

        chk("final_q_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
